rover_sequencer: RTL

- Mission-level controller for the rover.
- Gates the pathing module's motor drive. Stops the rover at each station marker and lets the motors settle. Sweeps the aiming servo until the frequency module reports a beacon, holds aim for a dwell period, then recentres the servo and resumes path following.
- Sits between the pathing, frequency, servo-aim and seven-segment modules in the top level.

---
 rtl/rover_pkg.sv | 25 ++
 rtl/seq_timer.sv | 40 ++++
 rtl/rover_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rover_pkg.sv
// Shared types and constants for the rover mission sequencer.
package rover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_BRAKE  = 3'd2,
        ST_SWEEP  = 3'd3,
        ST_LOCK   = 3'd4,
        ST_RESUME = 3'd5
    } seq_state_t;

    localparam logic [1:0] FREQ_NONE      = 2'd0;
    localparam logic [7:0] CENTER_POS_DEF = 8'd128;

    // First nonzero channel wins, F over S over G.
    function automatic logic [1:0] pick_freq(input logic [1:0] f,
                                             input logic [1:0] s,
                                             input logic [1:0] g);
        if (f != FREQ_NONE) return f;
        if (s != FREQ_NONE) return s;
        return g;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count expires.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         active_q, active_d;

    assign done = active_q && (cnt_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = load_val;
            active_d = 1'b1;
        end else if (done) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/rover_sequencer.sv
// Mission sequencer: follow path, brake at stations, sweep servo for a beacon, dwell, resume.
// Define ROVER_SEQ_DEBOUNCE_EN to require the same code on two consecutive step ticks before locking.
//
// state  | meaning
// IDLE   | waiting for start, motors off
// FOLLOW | path following, motors on
// BRAKE  | motors off, settling before sweep
// SWEEP  | stepping servo, sampling frequency channels each tick
// LOCK   | servo held on detected target for the dwell period
// RESUME | one cycle: recentre servo, count station
module rover_sequencer
    import rover_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 5_000_000,
    parameter int         STEP_CYCLES   = 1_000_000,
    parameter int         SWEEP_STEP    = 8,
    parameter int         DWELL_CYCLES  = 100_000_000,
    parameter int         MAX_SWEEPS    = 2,
    parameter logic [7:0] CENTER_POS    = CENTER_POS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       station_hit,
    input  logic [1:0] Ffreq,
    input  logic [1:0] Sfreq,
    input  logic [1:0] Gfreq,
    output logic       drive_en,
    output logic [7:0] positionServo,
    output logic [1:0] target_code,
    output logic [2:0] seq_state,
    output logic [3:0] station_cnt
);

    localparam int TMR_MAX_A = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > DWELL_CYCLES) ? TMR_MAX_A : DWELL_CYCLES;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int SW_W      = (MAX_SWEEPS > 1) ? $clog2(MAX_SWEEPS) : 1;

    localparam logic [TMR_W-1:0] SETTLE_TC = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STEP_TC   = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0] DWELL_TC  = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [SW_W-1:0]  SWEEP_TC  = SW_W'(MAX_SWEEPS - 1);
    localparam logic [7:0]       STEP_INC  = 8'(SWEEP_STEP);

    seq_state_t       state_q, state_d;
    logic             drive_q, drive_d;
    logic [7:0]       pos_q, pos_d;
    logic [1:0]       target_q, target_d;
    logic [3:0]       stn_q, stn_d;
    logic [SW_W-1:0]  sweep_q, sweep_d;
`ifdef ROVER_SEQ_DEBOUNCE_EN
    logic [1:0]       cand_q, cand_d;
`endif

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic [1:0]       det;
    logic [8:0]       pos_sum;
    logic             do_lock, do_adv;
    logic [1:0]       lock_code;

    seq_timer #(.W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign det     = pick_freq(Ffreq, Sfreq, Gfreq);
    assign pos_sum = {1'b0, pos_q} + {1'b0, STEP_INC};

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        target_d  = target_q;
        stn_d     = stn_q;
        sweep_d   = sweep_q;
`ifdef ROVER_SEQ_DEBOUNCE_EN
        cand_d    = cand_q;
`endif
        tmr_load  = 1'b0;
        tmr_val   = STEP_TC;
        do_lock   = 1'b0;
        do_adv    = 1'b0;
        lock_code = FREQ_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FOLLOW;
            end
            ST_FOLLOW: begin
                if (station_hit) begin
                    state_d  = ST_BRAKE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_TC;
                end
            end
            ST_BRAKE: begin
                if (tmr_done) begin
                    state_d  = ST_SWEEP;
                    pos_d    = '0;
                    sweep_d  = '0;
`ifdef ROVER_SEQ_DEBOUNCE_EN
                    cand_d   = FREQ_NONE;
`endif
                    tmr_load = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
`ifdef ROVER_SEQ_DEBOUNCE_EN
                    if (cand_q != FREQ_NONE && det == cand_q) begin
                        do_lock   = 1'b1;
                        lock_code = cand_q;
                    end else if (cand_q == FREQ_NONE && det != FREQ_NONE) begin
                        cand_d = det;
                    end else begin
                        cand_d = FREQ_NONE;
                        do_adv = 1'b1;
                    end
`else
                    if (det != FREQ_NONE) begin
                        do_lock   = 1'b1;
                        lock_code = det;
                    end else begin
                        do_adv = 1'b1;
                    end
`endif
                end
            end
            ST_LOCK: begin
                if (tmr_done) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                state_d = ST_FOLLOW;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_lock) begin
            state_d  = ST_LOCK;
            target_d = lock_code;
            tmr_val  = DWELL_TC;
        end

        // A wrap restarts the sweep at zero; the last allowed wrap abandons the station.
        if (do_adv) begin
            if (pos_sum[8]) begin
                pos_d = '0;
                if (sweep_q == SWEEP_TC) begin
                    state_d  = ST_RESUME;
                    target_d = FREQ_NONE;
                end else begin
                    sweep_d = sweep_q + SW_W'(1);
                end
            end else begin
                pos_d = pos_sum[7:0];
            end
        end

        if (state_d == ST_RESUME) begin
            pos_d = CENTER_POS;
            if (stn_q != 4'd15) stn_d = stn_q + 4'd1;
        end

        drive_d = (state_d == ST_FOLLOW);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            drive_q  <= 1'b0;
            pos_q    <= CENTER_POS;
            target_q <= FREQ_NONE;
            stn_q    <= '0;
            sweep_q  <= '0;
`ifdef ROVER_SEQ_DEBOUNCE_EN
            cand_q   <= FREQ_NONE;
`endif
        end else begin
            state_q  <= state_d;
            drive_q  <= drive_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            stn_q    <= stn_d;
            sweep_q  <= sweep_d;
`ifdef ROVER_SEQ_DEBOUNCE_EN
            cand_q   <= cand_d;
`endif
        end
    end

    assign drive_en      = drive_q;
    assign positionServo = pos_q;
    assign target_code   = target_q;
    assign seq_state     = state_q;
    assign station_cnt   = stn_q;

endmodule
